mips_mem_responder: RTL and testbench
=====================================

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 The block SHALL have parameter ADRBITS, default 6, giving the number of implemented byte locations (2**ADRBITS = 64).
REQ-002 The block SHALL have port clk, input, 1: clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port memread, input, 1: CPU read request for the current cycle.
REQ-005 The block SHALL have port memwrite, input, 1: CPU write request for the current cycle.
REQ-006 The block SHALL have port adr, input, 8: CPU byte address.
REQ-007 The block SHALL have port writedata, input, 8: CPU store data.
REQ-008 The block SHALL have port memdata, output, 8: read data to the CPU, valid in the same cycle.
REQ-009 The block SHALL have port cpu_reset, output, 1: holds the CPU in reset.
REQ-010 The block SHALL have port ld_go, input, 1: one-cycle pulse that starts a program load.
REQ-011 The block SHALL have port ld_valid, input, 1: host load byte valid.
REQ-012 The block SHALL have port ld_data, input, 8: host load byte.
REQ-013 The block SHALL have port ld_last, input, 1: marks the final load byte.
REQ-014 The block SHALL have port ld_ready, output, 1: block accepts a load byte this cycle.
REQ-015 The block SHALL have port wr_strobe, output, 1: one-cycle pulse reporting an accepted CPU write.
REQ-016 The block SHALL have port wr_adr, output, 8: address of the last accepted CPU write.
REQ-017 The block SHALL have port wr_data, output, 8: data of the last accepted CPU write.
REQ-018 The block SHALL have port err_oor, output, 1: sticky flag for a CPU access outside the implemented range.

Function
REQ-019 The state machine SHALL have three states, IDLE, LOAD and RUN, held in a registered state variable.
REQ-020 State transitions SHALL be:
- IDLE to LOAD on ld_go.
- LOAD to RUN on an accepted byte with ld_last=1, or on acceptance of the byte at address 2**ADRBITS-1.
- RUN to LOAD on ld_go.
- ld_go in LOAD SHALL restart the load pointer at 0.
REQ-021 cpu_reset SHALL equal 1 whenever state is not RUN, decoded directly from the state register.
REQ-022 ld_ready SHALL be 1 only in LOAD; a byte is accepted when ld_valid & ld_ready.
REQ-023 On acceptance, ld_data SHALL be written at the load pointer, and the pointer (ADRBITS wide, starting at 0 on entry to LOAD) SHALL increment by 1.
REQ-024 In RUN, memdata SHALL be mem[adr[ADRBITS-1:0]] combinationally when memread=1 and adr < 2**ADRBITS; otherwise memdata SHALL be 0.
REQ-025 In RUN, memwrite=1 with adr in range SHALL write writedata at the clock edge.
REQ-026 When memread and memwrite are both 1, the write SHALL occur and memdata SHALL return the pre-write byte.
REQ-027 An accepted CPU write SHALL pulse wr_strobe for the next cycle, and wr_adr/wr_data SHALL be registered with the same edge and hold until the next accepted write.
REQ-028 A CPU memread or memwrite in RUN with adr >= 2**ADRBITS SHALL set err_oor, and an out-of-range write SHALL be ignored.
- err_oor SHALL clear only on reset or on entry to LOAD.
REQ-029 Outside RUN, memread and memwrite SHALL be ignored: no write, memdata=0, no err_oor, no wr_strobe.
REQ-030 When ld_go arrives in the same cycle as a CPU memwrite in RUN, the write SHALL complete and the next state SHALL be LOAD.

Reset
REQ-031 Reset SHALL set state=IDLE, load pointer=0, wr_strobe=0, wr_adr=0, wr_data=0 and err_oor=0, giving cpu_reset=1, ld_ready=0 and memdata=0.
REQ-032 Reset SHALL NOT clear memory contents.
REQ-033 Reset SHALL take priority over ld_go and over any in-progress load.

Structure
REQ-034 A shared package mips_mem_pkg SHALL hold the memstate enum (IDLE, LOAD, RUN) and the MEMBYTES constant.
REQ-035 The byte array SHALL be a sub-module bytemem with one synchronous write port and one combinational read port.
REQ-036 The load/run FSM, load pointer and write monitor SHALL reside in mips_mem_responder.

Verification
REQ-037 Load test: ld_go, then bytes 0x80,0x01,0x02,0x03 with ld_last on the 4th -> ld_ready high for 4 cycles, state RUN, cpu_reset=0; memread adr=2 -> memdata=0x02.
REQ-038 Full load test: 64 bytes without ld_last -> RUN after the 64th byte; a 65th ld_valid is not accepted (ld_ready=0).
REQ-039 CPU write test: RUN, memwrite adr=0x10 writedata=0x5A -> next cycle wr_strobe=1, wr_adr=0x10, wr_data=0x5A; memread adr=0x10 -> 0x5A.
REQ-040 Out-of-range test: RUN, memwrite adr=0x40 data=0xFF -> err_oor=1, no wr_strobe, mem[0x00] unchanged; a later ld_go clears err_oor.
REQ-041 Reset mid-load test: reset after 2 of 4 bytes -> IDLE, cpu_reset=1, ld_ready=0; loaded bytes retained for readback after the next load.
REQ-042 Simultaneous test: read+write adr=5 (old 0x11, new 0x22) -> memdata=0x11 that cycle, then 0x22.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS program memory responder.
// Holds the load/run state encoding and default memory size.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } memstate_t;

    localparam int MEMBYTES = 64;

endpackage

// File: rtl/bytemem.sv
// Byte array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module bytemem #(
    parameter int ADRBITS = 6
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADRBITS-1:0] wa,
    input  logic [7:0]         wd,
    input  logic [ADRBITS-1:0] ra,
    output logic [7:0]         rd
);

    logic [7:0] mem [2**ADRBITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/mips_mem_responder.sv
// CPU-facing program memory with host load port and write monitor.
// The CPU is held in reset until a load completes.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADRBITS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       memread,
    input  logic       memwrite,
    input  logic [7:0] adr,
    input  logic [7:0] writedata,
    output logic [7:0] memdata,
    output logic       cpu_reset,
    input  logic       ld_go,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       wr_strobe,
    output logic [7:0] wr_adr,
    output logic [7:0] wr_data,
    output logic       err_oor
);

    localparam int unsigned NBYTES = 1 << ADRBITS;

    memstate_t          state_q;
    memstate_t          state_d;
    logic [ADRBITS-1:0] ptr_q;
    logic               run;
    logic               in_range;
    logic               accept;
    logic               cpu_we;
    logic               cpu_oor;
    logic               mem_we;
    logic [ADRBITS-1:0] mem_wa;
    logic [7:0]         mem_wd;
    logic [7:0]         mem_rd;

    assign run       = (state_q == RUN);
    assign cpu_reset = (state_q != RUN);
    assign ld_ready  = (state_q == LOAD);
    assign in_range  = (32'(adr) < NBYTES);
    assign accept    = ld_valid & ld_ready;
    assign cpu_we    = run & memwrite & in_range;
    assign cpu_oor   = run & (memread | memwrite) & ~in_range;

    // Reset blocks all array writes; CPU and load writes never overlap.
    assign mem_we = ~reset & (cpu_we | accept);
    assign mem_wa = cpu_we ? adr[ADRBITS-1:0] : ptr_q;
    assign mem_wd = cpu_we ? writedata : ld_data;

    assign memdata = (run & memread & in_range) ? mem_rd : 8'h00;

    bytemem #(
        .ADRBITS(ADRBITS)
    ) u_mem (
        .clk(clk),
        .we (mem_we),
        .wa (mem_wa),
        .wd (mem_wd),
        .ra (adr[ADRBITS-1:0]),
        .rd (mem_rd)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ld_go) state_d = LOAD;
            end
            LOAD: begin
                if (ld_go) begin
                    state_d = LOAD;
                end else if (accept && (ld_last || (&ptr_q))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ld_go) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            err_oor <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_go) begin
                ptr_q   <= '0;
                err_oor <= 1'b0;
            end else begin
                if (accept) ptr_q <= ptr_q + 1'b1;
                if (cpu_oor) err_oor <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_strobe <= 1'b0;
            wr_adr    <= 8'h00;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= cpu_we;
            if (cpu_we) begin
                wr_adr  <= adr;
                wr_data <= writedata;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: directed scenarios
// followed by random traffic against a behavioural model.
module tb_mips_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       memread;
    logic       memwrite;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic [7:0] memdata;
    logic       cpu_reset;
    logic       ld_go;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       wr_strobe;
    logic [7:0] wr_adr;
    logic [7:0] wr_data;
    logic       err_oor;

    mips_mem_responder #(.ADRBITS(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .memread  (memread),
        .memwrite (memwrite),
        .adr      (adr),
        .writedata(writedata),
        .memdata  (memdata),
        .cpu_reset(cpu_reset),
        .ld_go    (ld_go),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .wr_strobe(wr_strobe),
        .wr_adr   (wr_adr),
        .wr_data  (wr_data),
        .err_oor  (err_oor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       chk_md;
        logic [7:0] md;
        logic       cr;
        logic       rdy;
        logic       ws;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       err;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model: mode 0 idle, 1 loading, 2 running.
    int         m_mode;
    int         m_ptr;
    logic [7:0] m_mem [64];
    bit         m_known [64];
    logic       m_ws;
    logic [7:0] m_wa;
    logic [7:0] m_wd;
    logic       m_err;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if ((e.chk_md && memdata !== e.md) ||
                cpu_reset !== e.cr || ld_ready !== e.rdy ||
                wr_strobe !== e.ws || wr_adr !== e.wa ||
                wr_data !== e.wd || err_oor !== e.err) begin
                errors++;
                $display("FAIL %s: got md=%h cr=%b rdy=%b ws=%b wa=%h wd=%h err=%b exp md=%h(%b) cr=%b rdy=%b ws=%b wa=%h wd=%h err=%b",
                    e.tag, memdata, cpu_reset, ld_ready, wr_strobe,
                    wr_adr, wr_data, err_oor, e.md, e.chk_md, e.cr,
                    e.rdy, e.ws, e.wa, e.wd, e.err);
            end
        end
    end

    task automatic step(
        input string      tag,
        input logic       r,
        input logic       mr,
        input logic       mw,
        input logic [7:0] a,
        input logic [7:0] wdat,
        input logic       go,
        input logic       v,
        input logic [7:0] d,
        input logic       last,
        input bit         check
    );
        exp_t e;
        int   nxt;
        reset     = r;
        memread   = mr;
        memwrite  = mw;
        adr       = a;
        writedata = wdat;
        ld_go     = go;
        ld_valid  = v;
        ld_data   = d;
        ld_last   = last;
        e.tag = tag;
        e.cr  = (m_mode != 2);
        e.rdy = (m_mode == 1);
        e.ws  = m_ws;
        e.wa  = m_wa;
        e.wd  = m_wd;
        e.err = m_err;
        if (m_mode == 2 && mr && a < 64) begin
            e.md     = m_mem[a];
            e.chk_md = m_known[a];
        end else begin
            e.md     = 8'h00;
            e.chk_md = 1'b1;
        end
        if (check) exp_q.push_back(e);
        if (r) begin
            m_mode = 0;
            m_ptr  = 0;
            m_ws   = 1'b0;
            m_wa   = 8'h00;
            m_wd   = 8'h00;
            m_err  = 1'b0;
        end else begin
            nxt  = m_mode;
            m_ws = 1'b0;
            if (m_mode == 2 && mw && a < 64) begin
                m_mem[a]   = wdat;
                m_known[a] = 1;
                m_ws = 1'b1;
                m_wa = a;
                m_wd = wdat;
            end
            if (m_mode == 2 && (mr || mw) && a >= 64) m_err = 1'b1;
            if (m_mode == 1 && v) begin
                m_mem[m_ptr]   = d;
                m_known[m_ptr] = 1;
                if (last || m_ptr == 63) nxt = 2;
                m_ptr = (m_ptr + 1) % 64;
            end
            if (go) begin
                nxt   = 1;
                m_ptr = 0;
                m_err = 1'b0;
            end
            m_mode = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1);
    endtask

    task automatic rd(input string tag, input logic [7:0] a);
        step(tag, 0, 1, 0, a, 8'h00, 0, 0, 8'h00, 0, 1);
    endtask

    task automatic wr(input string tag, input logic [7:0] a,
                      input logic [7:0] d);
        step(tag, 0, 0, 1, a, d, 0, 0, 8'h00, 0, 1);
    endtask

    task automatic go(input string tag);
        step(tag, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1);
    endtask

    task automatic ld(input string tag, input logic [7:0] d,
                      input logic last);
        step(tag, 0, 0, 0, 8'h00, 8'h00, 0, 1, d, last, 1);
    endtask

    initial begin
        logic [7:0] seq [4];
        seq[0] = 8'h80;
        seq[1] = 8'h01;
        seq[2] = 8'h02;
        seq[3] = 8'h03;
        m_mode = 0;
        m_ptr  = 0;
        m_ws   = 1'b0;
        m_wa   = 8'h00;
        m_wd   = 8'h00;
        m_err  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_mem[i]   = 8'h00;
            m_known[i] = 0;
        end
        #1;
        step("rst0", 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);
        step("rst1", 1, 1, 1, 8'h03, 8'h77, 1, 1, 8'h44, 0, 1);
        idle("reset_state");
        rd("idle_read_zero", 8'h02);

        go("load_go");
        for (int i = 0; i < 4; i++) ld("load4", seq[i], i == 3);
        idle("run_entered");
        rd("read_adr2", 8'h02);
        rd("read_adr0", 8'h00);

        go("full_go");
        for (int i = 0; i < 64; i++)
            ld("full_load", 8'(i * 7 + 3), 0);
        ld("byte65_rejected", 8'hEE, 0);
        rd("full_read63", 8'h3F);
        rd("full_read0", 8'h00);

        wr("cpu_wr10", 8'h10, 8'h5A);
        idle("wr_strobe");
        rd("read10", 8'h10);

        wr("oor_wr40", 8'h40, 8'hFF);
        idle("oor_flag");
        rd("mem0_unchanged", 8'h00);
        rd("oor_rd_ff", 8'hFF);
        go("oor_clear_go");
        idle("oor_cleared");
        ld("reload0", 8'hA5, 1);
        idle("reload_run");

        go("mid_go");
        ld("mid_b0", 8'h31, 0);
        ld("mid_b1", 8'h32, 0);
        step("mid_reset", 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h33, 0, 1);
        idle("mid_idle");
        ld("mid_ignored", 8'h99, 1);
        go("mid_reload");
        ld("mid_one", 8'h41, 1);
        rd("retained1", 8'h01);
        rd("retained0", 8'h00);

        wr("sim_pre", 8'h05, 8'h11);
        step("sim_rw", 0, 1, 1, 8'h05, 8'h22, 0, 0, 8'h00, 0, 1);
        rd("sim_after", 8'h05);
        step("go_with_wr", 0, 0, 1, 8'h07, 8'h6C, 1, 0, 8'h00, 0, 1);
        ld("gw_load", 8'h01, 1);
        rd("gw_read7", 8'h07);

        for (int i = 0; i < 600; i++) begin
            logic       r, mr, mw, g, v, l;
            logic [7:0] a;
            r  = ($urandom_range(0, 99) < 2);
            g  = ($urandom_range(0, 99) < 4);
            mr = $urandom_range(0, 1) == 1;
            mw = ($urandom_range(0, 2) == 0);
            v  = $urandom_range(0, 1) == 1;
            l  = ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                              : 8'($urandom_range(0, 63));
            step("random", r, mr, mw, a, 8'($urandom), g, v,
                 8'($urandom), l, 1);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
